// File: rtl/touch_emu_pkg.sv
// -----------------------------------------------------------------------------
// touch_emu_pkg
// Shared definitions for the touch-controller I2C responder:
//   - state_e          : responder FSM states
//   - REG_*            : register-map addresses seen by the touch driver
//   - STATUS_READY     : "buffer ready" bit of the status register
//   - STATUS_POSTED    : status value after a point is committed (ready, 1 point)
//   - PID0..PID3       : product-ID bytes, ASCII "9147"
//   - shift_in()       : MSB-first serial shift helper
// -----------------------------------------------------------------------------
package touch_emu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG_H,
    ST_ACK_H,
    ST_REG_L,
    ST_ACK_L,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } state_e;

  localparam logic [15:0] REG_PID0    = 16'h8140;
  localparam logic [15:0] REG_PID1    = 16'h8141;
  localparam logic [15:0] REG_PID2    = 16'h8142;
  localparam logic [15:0] REG_PID3    = 16'h8143;
  localparam logic [15:0] REG_STATUS  = 16'h814E;
  localparam logic [15:0] REG_PT1_XL  = 16'h8150;
  localparam logic [15:0] REG_PT1_XH  = 16'h8151;
  localparam logic [15:0] REG_PT1_YL  = 16'h8152;
  localparam logic [15:0] REG_PT1_YH  = 16'h8153;

  localparam logic [7:0] STATUS_READY  = 8'h80;
  localparam logic [7:0] STATUS_POSTED = STATUS_READY | 8'h01;

  localparam logic [7:0] PID0 = 8'h39;  // '9'
  localparam logic [7:0] PID1 = 8'h31;  // '1'
  localparam logic [7:0] PID2 = 8'h34;  // '4'
  localparam logic [7:0] PID3 = 8'h37;  // '7'

  // Append one received bit to an MSB-first shift register.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Two-flop synchronizers for SCL/SDA plus single-cycle event strobes derived
// from the synchronized values.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   scl_i, sda_i : raw pad inputs
//   sda_o        : synchronized SDA level (sample on scl_rise_o)
//   scl_rise_o   : synchronized SCL rising edge
//   scl_fall_o   : synchronized SCL falling edge
//   start_o      : SDA fell while SCL high
//   stop_o       : SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_ff_q;
  logic [1:0] sda_ff_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Reset to the idle-bus level (both lines high) so no spurious edge is
  // reported while the bus is quiet after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff_q   <= 2'b11;
      sda_ff_q   <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_ff_q   <= {scl_ff_q[0], scl_i};
      sda_ff_q   <= {sda_ff_q[0], sda_i};
      scl_prev_q <= scl_ff_q[1];
      sda_prev_q <= sda_ff_q[1];
    end
  end

  assign sda_o      = sda_ff_q[1];
  assign scl_rise_o =  scl_ff_q[1] & ~scl_prev_q;
  assign scl_fall_o = ~scl_ff_q[1] &  scl_prev_q;
  // SCL must be high in both the current and previous sample so that an SDA
  // change coinciding with an SCL edge is never taken as START/STOP.
  assign start_o    = scl_ff_q[1] & scl_prev_q &  sda_prev_q & ~sda_ff_q[1];
  assign stop_o     = scl_ff_q[1] & scl_prev_q & ~sda_prev_q &  sda_ff_q[1];

endmodule

// File: rtl/touch_i2c_responder.sv
// -----------------------------------------------------------------------------
// touch_i2c_responder
// Emulates a capacitive touch controller on an I2C bus: 16-bit register
// pointer, product-ID / status / point registers, and an injected touch point
// that is committed to the register file only while no transfer is in flight.
// Optional macro: TOUCH_EMU_INT_EN enables the active-low INT pulse of
// INT_PULSE_CYC cycles after each commit; without it int_n is tied high.
// Parameters:
//   DEV_ADDR      : 7-bit responder address
//   INT_PULSE_CYC : INT low-pulse length in clk cycles
// Ports:
//   clk, rst_n           : system clock, asynchronous active-low reset
//   scl_i, sda_i         : I2C pad inputs
//   sda_oe               : 1 = pull SDA low (open-drain)
//   int_n                : touch interrupt, active low
//   inject_valid         : one-cycle strobe posting inject_x/inject_y
//   inject_x, inject_y   : point coordinates
//   busy                 : high from an addressed START through STOP
// -----------------------------------------------------------------------------
module touch_i2c_responder
  import touch_emu_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h14,
  parameter int         INT_PULSE_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        int_n,
  input  logic        inject_valid,
  input  logic [15:0] inject_x,
  input  logic [15:0] inject_y,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Bus synchronizer
  // ---------------------------------------------------------------------------
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rd_byte_q;
  logic [15:0] ptr_q;
  logic        ack_drv_q;   // ACK slot: 0 = waiting to drive, 1 = driving
  logic        sda_oe_q;
  logic        busy_q;

  logic [7:0]  status_q;
  logic [15:0] pt_x_q;
  logic [15:0] pt_y_q;
  logic        pend_valid_q;
  logic [15:0] pend_x_q;
  logic [15:0] pend_y_q;

  logic [7:0]  rx_byte;
  logic [7:0]  rd_cur;
  logic [7:0]  rd_nxt;
  logic        commit;
  logic        status_clr;

  // ---------------------------------------------------------------------------
  // Register-file read decode
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] reg_read(
    input logic [15:0] addr,
    input logic [7:0]  status,
    input logic [15:0] px,
    input logic [15:0] py
  );
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      REG_PID0:   r = PID0;
      REG_PID1:   r = PID1;
      REG_PID2:   r = PID2;
      REG_PID3:   r = PID3;
      REG_STATUS: r = status;
      REG_PT1_XL: r = px[7:0];
      REG_PT1_XH: r = px[15:8];
      REG_PT1_YL: r = py[7:0];
      REG_PT1_YH: r = py[15:8];
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  assign rx_byte = shift_in(shift_q, sda_s);
  assign rd_cur  = reg_read(ptr_q,         status_q, pt_x_q, pt_y_q);
  assign rd_nxt  = reg_read(ptr_q + 16'd1, status_q, pt_x_q, pt_y_q);

  // A pending point may only land while no transfer is in flight, so a read
  // burst never sees a half-updated coordinate pair.
  assign commit = pend_valid_q & ~busy_q;

  // Completed WDATA byte addressed to the status register clears it.
  assign status_clr = (state_q == ST_WDATA) && scl_rise &&
                      (bit_cnt_q == 3'd7) && (ptr_q == REG_STATUS);

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rd_byte_q <= 8'h00;
      ptr_q     <= 16'h0000;
      ack_drv_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (stop_det) begin
      state_q   <= ST_IDLE;
      sda_oe_q  <= 1'b0;
      ack_drv_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (start_det) begin
      // busy is kept across a repeated START: the transaction is still open.
      state_q   <= ST_ADDR;
      bit_cnt_q <= 3'd0;
      sda_oe_q  <= 1'b0;
      ack_drv_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG_H, ST_REG_L, ST_WDATA: begin
          if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;   // wraps to 0 after the 8th bit
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= ST_ACK_ADDR;
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= ST_IGNORE;
                  end
                end
                ST_REG_H: begin
                  ptr_q[15:8] <= rx_byte;
                  state_q     <= ST_ACK_H;
                end
                ST_REG_L: begin
                  ptr_q[7:0] <= rx_byte;
                  state_q    <= ST_ACK_L;
                end
                default: begin
                  // WDATA: the write itself is decoded by status_clr.
                  ptr_q   <= ptr_q + 16'd1;
                  state_q <= ST_ACK_W;
                end
              endcase
            end
          end
        end

        // ACK slot: first SCL fall (end of bit 0) pulls SDA, second SCL fall
        // (end of the ACK slot) releases it and moves on. shift_q still holds
        // the address byte here, so bit 0 is the R/W flag.
        ST_ACK_ADDR, ST_ACK_H, ST_ACK_L, ST_ACK_W: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_q  <= 1'b1;
              ack_drv_q <= 1'b1;
            end else begin
              ack_drv_q <= 1'b0;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              case (state_q)
                ST_ACK_ADDR: begin
                  if (shift_q[0]) begin
                    // Read: latch the byte and present its MSB on this same
                    // fall, since the master samples it on the next rise.
                    state_q   <= ST_RDATA;
                    rd_byte_q <= rd_cur;
                    sda_oe_q  <= ~rd_cur[7];
                  end else begin
                    state_q <= ST_REG_H;
                  end
                end
                ST_ACK_H: state_q <= ST_REG_L;
                default:  state_q <= ST_WDATA;
              endcase
            end
          end
        end

        // bit_cnt counts bits already sampled by the master; each SCL fall
        // presents the next bit. Entered from MACK with bit_cnt=0, the first
        // fall presents the MSB; entered from ACK_ADDR the MSB is already out.
        ST_RDATA: begin
          if (scl_fall) begin
            sda_oe_q <= ~rd_byte_q[3'd7 - bit_cnt_q];
          end
          if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_MACK;
            end
          end
        end

        ST_MACK: begin
          if (scl_fall) begin
            sda_oe_q <= 1'b0;
          end
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_q     <= ptr_q + 16'd1;
              rd_byte_q <= rd_nxt;
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RDATA;
            end else begin
              state_q <= ST_IGNORE;
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
          sda_oe_q <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Point registers, status and pending buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q     <= 8'h00;
      pt_x_q       <= 16'h0000;
      pt_y_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      pend_x_q     <= 16'h0000;
      pend_y_q     <= 16'h0000;
    end else begin
      if (commit) begin
        status_q <= STATUS_POSTED;
        pt_x_q   <= pend_x_q;
        pt_y_q   <= pend_y_q;
      end else if (status_clr) begin
        status_q <= 8'h00;
      end
      // An inject arriving together with a commit stays pending for the
      // next commit.
      pend_valid_q <= inject_valid | (pend_valid_q & ~commit);
      if (inject_valid) begin
        pend_x_q <= inject_x;
        pend_y_q <= inject_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
`ifdef TOUCH_EMU_INT_EN
  localparam int CNT_W = $clog2(INT_PULSE_CYC + 1);
  logic [CNT_W-1:0] int_cnt_q;

  // Counter loads on commit, so int_n is low for the INT_PULSE_CYC cycles
  // that follow; a commit mid-pulse simply reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt_q <= '0;
    end else if (commit) begin
      int_cnt_q <= CNT_W'(INT_PULSE_CYC);
    end else if (int_cnt_q != '0) begin
      int_cnt_q <= int_cnt_q - CNT_W'(1);
    end
  end

  assign int_n = (int_cnt_q == '0);
`else
  logic unused_int_cfg;
  assign unused_int_cfg = (INT_PULSE_CYC != 0);
  assign int_n          = 1'b1;
`endif

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_touch_i2c_responder.sv
// -----------------------------------------------------------------------------
// tb_touch_i2c_responder
// Directed bench for touch_i2c_responder: a bit-banged I2C master drives the
// bus (SCL quarter period = 10 clk), expected values are hand-computed.
// With TOUCH_EMU_INT_EN defined the INT pulse length is expected to be 500.
// -----------------------------------------------------------------------------
module tb_touch_i2c_responder;

  localparam int Q = 10;   // clk cycles per SCL quarter period

`ifdef TOUCH_EMU_INT_EN
  localparam int EXP_PULSE = 500;
`else
  localparam int EXP_PULSE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        inject_valid = 1'b0;
  logic [15:0] inject_x = 16'h0000;
  logic [15:0] inject_y = 16'h0000;
  logic        sda_oe;
  logic        int_n;
  logic        busy;
  logic        sda_bus;

  int          checks = 0;
  int          errors = 0;
  int          oe_cnt = 0;
  logic [7:0]  rbuf [8];

  assign sda_bus = sda_m & ~sda_oe;   // open-drain wired-AND

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  touch_i2c_responder #(
    .DEV_ADDR      (7'h14),
    .INT_PULSE_CYC (500)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .int_n        (int_n),
    .inject_valid (inject_valid),
    .inject_x     (inject_x),
    .inject_y     (inject_y),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wq();
    scl   = 1'b1; wq(); wq();
    scl   = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    b     = sda_bus; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
    $display("  txn wr 0x%02h ack=%0b", b, ack);
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic nack);
    logic       bt;
    logic [7:0] tmp;
    tmp = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      tmp[i] = bt;
    end
    write_bit(nack);
    b = tmp;
    $display("  txn rd 0x%02h nack=%0b", tmp, nack);
  endtask

  // START, write-address, 16-bit pointer; leaves the transaction open.
  task automatic set_ptr(input logic [15:0] p);
    logic a;
    i2c_start();
    wr_byte(8'h28, a);     check("ack_addr_w", a, 1'b0);
    wr_byte(p[15:8], a);   check("ack_ptr_h", a, 1'b0);
    wr_byte(p[7:0], a);    check("ack_ptr_l", a, 1'b0);
  endtask

  // Pointer write, repeated START, n-byte read (NACK last), STOP.
  task automatic read_from(input logic [15:0] p, input int n);
    logic a;
    set_ptr(p);
    i2c_start();
    wr_byte(8'h29, a);     check("ack_addr_r", a, 1'b0);
    for (int i = 0; i < n; i++) rd_byte(rbuf[i], (i == n - 1));
    i2c_stop();
  endtask

  task automatic inject(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    inject_x = x; inject_y = y; inject_valid = 1'b1;
    @(negedge clk);
    inject_valid = 1'b0;
    $display("  txn inject x=0x%04h y=0x%04h", x, y);
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    int lo;
    int oe0;

    // ---- reset ----
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_int_n", int_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wq();

    // ---- product ID probe ----
    set_ptr(16'h8140);
    check("busy_addressed", busy, 1'b1);
    i2c_start();
    wr_byte(8'h29, a);  check("ack_addr_r", a, 1'b0);
    for (int i = 0; i < 4; i++) rd_byte(rbuf[i], (i == 3));
    i2c_stop();
    check("pid0", rbuf[0], 8'h39);
    check("pid1", rbuf[1], 8'h31);
    check("pid2", rbuf[2], 8'h34);
    check("pid3", rbuf[3], 8'h37);
    wq();
    check("busy_after_stop", busy, 1'b0);

    // ---- idle inject, INT pulse, point readback ----
    inject(16'h01E0, 16'h0110);
    lo = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (int_n === 1'b0) lo++;
    end
    check("int_pulse_len", lo, EXP_PULSE);
    read_from(16'h814E, 6);
    check("status_posted", rbuf[0], 8'h81);
    check("reg_814f", rbuf[1], 8'h00);
    check("x_lo", rbuf[2], 8'hE0);
    check("x_hi", rbuf[3], 8'h01);
    check("y_lo", rbuf[4], 8'h10);
    check("y_hi", rbuf[5], 8'h01);

    // ---- status clear by write ----
    set_ptr(16'h814E);
    wr_byte(8'h00, a);  check("ack_wdata", a, 1'b0);
    i2c_stop();
    read_from(16'h814E, 1);
    check("status_cleared", rbuf[0], 8'h00);

    // ---- inject during a read burst ----
    set_ptr(16'h8150);
    i2c_start();
    wr_byte(8'h29, a);  check("ack_addr_r", a, 1'b0);
    rd_byte(b, 1'b0);   check("mid_x_lo", b, 8'hE0);
    inject(16'h1234, 16'h5678);
    wq();
    check("mid_busy", busy, 1'b1);
    check("mid_int_n", int_n, 1'b1);
    rd_byte(b, 1'b0);   check("mid_x_hi_old", b, 8'h01);
    rd_byte(b, 1'b0);   check("mid_y_lo_old", b, 8'h10);
    rd_byte(b, 1'b1);   check("mid_y_hi_old", b, 8'h01);
    i2c_stop();
    read_from(16'h814E, 6);
    check("post_stop_status", rbuf[0], 8'h81);
    check("new_x_lo", rbuf[2], 8'h34);
    check("new_x_hi", rbuf[3], 8'h12);
    check("new_y_lo", rbuf[4], 8'h78);
    check("new_y_hi", rbuf[5], 8'h56);

    // ---- write burst: pointer increments onto the status register ----
    set_ptr(16'h814D);
    wr_byte(8'hAA, a);  check("ack_unmapped_wr", a, 1'b0);
    wr_byte(8'h55, a);  check("ack_status_wr", a, 1'b0);
    i2c_stop();
    read_from(16'h814D, 2);
    check("unmapped_814d", rbuf[0], 8'h00);
    check("status_cleared_inc", rbuf[1], 8'h00);

    // ---- wrong address ----
    oe0 = oe_cnt;
    i2c_start();
    wr_byte(8'h2A, a);  check("wrong_addr_nack", a, 1'b1);
    wr_byte(8'h00, a);  check("ignored_byte_nack", a, 1'b1);
    check("wrong_addr_busy", busy, 1'b0);
    i2c_stop();
    check("wrong_addr_oe_cycles", oe_cnt - oe0, 0);

    // ---- pointer wrap ----
    read_from(16'hFFFF, 2);
    check("ptr_ffff", rbuf[0], 8'h00);
    check("ptr_wrap_0000", rbuf[1], 8'h00);

    // ---- reset in the middle of a read byte ----
    inject(16'hABCD, 16'h0001);
    wq();
    read_from(16'h814E, 1);
    check("status_before_rst", rbuf[0], 8'h81);
    set_ptr(16'h8140);
    i2c_start();
    wr_byte(8'h29, a);  check("ack_addr_r", a, 1'b0);
    read_bit(a);        check("pid0_msb", a, 1'b0);
    check("oe_mid_byte", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("oe_released_in_rst", sda_oe, 1'b0);
    check("busy_in_rst", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wq();
    scl = 1'b1;
    wq();
    read_from(16'h814E, 4);
    check("status_after_rst", rbuf[0], 8'h00);
    check("x_lo_after_rst", rbuf[2], 8'h00);
    check("x_hi_after_rst", rbuf[3], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_i2c_responder.md
# touch_i2c_responder

I2C responder that emulates the capacitive touch controller on the touch I2C bus. It answers the touch driver's register writes and reads with an injected touch point, status byte and product ID. It pulses the INT line when a new point is posted. It lets the vending-machine FSM and the touch driver run on boards without a panel fitted, and it serves as the bus model in system benches.

## Interface
- DEV_ADDR, 7'h14: 7-bit responder address.
- INT_PULSE_CYC, 500: INT low-pulse length in clk cycles.
- clk  in  1  system clock, ≥ 20× SCL frequency.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL from pad (no clock stretching; SCL is input only).
- sda_i  in  1  SDA from pad.
- sda_oe  out  1  1 = pull SDA low (open-drain); the pad drives Z when 0.
- int_n  out  1  touch interrupt, active low.
- inject_valid  in  1  one-cycle strobe: post a new touch point.
- inject_x  in  16  X coordinate.
- inject_y  in  16  Y coordinate.
- busy  out  1  high from an addressed START through STOP.

## Operation
- scl_i/sda_i pass through 2-FF synchronizers; edges are detected on the synchronized values.
- START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both are valid in any state.
- START (incl. repeated) → ADDR. STOP → IDLE.
- States: IDLE, ADDR, ACK_ADDR, REG_H, ACK_H, REG_L, ACK_L, WDATA, ACK_W, RDATA, MACK, IGNORE.
- ADDR shifts 8 bits MSB-first on SCL rise.
  - Address match + R/W=0 → ACK_ADDR → REG_H.
  - Address match + R/W=1 → ACK_ADDR → RDATA. The pointer is unchanged from the last write.
  - Mismatch → IGNORE. sda_oe stays 0 until the next START/STOP.
- REG_H, then REG_L, load the 16-bit pointer MSB first. Each byte is ACKed. Further bytes go to WDATA.
- WDATA: each byte is written to the pointer register and ACKed. The pointer then increments.
- RDATA: shift out the register at the pointer, MSB first. MACK samples the master's bit.
  - ACK (0) → pointer+1 → RDATA.
  - NACK (1) → IGNORE until STOP/START.
- Pointer is 16 bits and wraps 0xFFFF → 0x0000.
- Register map (unmapped reads return 0x00; unmapped writes are ACKed and ignored):
  - 0x8140–0x8143: ASCII "9147", read-only.
  - 0x814E: status. bit7 = buffer ready, bits3:0 = point count (0 or 1). Writing any value clears it to 0x00.
  - 0x8150/0x8151: X lo/hi. 0x8152/0x8153: Y lo/hi.
- inject_valid captures X/Y into a pending buffer.
  - Pending data is committed to the point registers and status (=0x81) only while busy=0. Commit is immediate if idle, otherwise on the cycle after STOP.
  - A newer inject overwrites an uncommitted one.
  - An inject while status is already 0x81 overwrites the point; status stays 0x81.
- A status clear (write to 0x814E) and a commit in the same cycle cannot occur, because commit needs busy=0.

## Timing
- Reset values: sda_oe=0, int_n=1, busy=0, status=0x00, X/Y=0, pointer=0x0000, state IDLE, no pending point.
- Reset mid-transfer: SDA is released at once. The FSM stays in IDLE until the next START, so a partial frame is dropped.
- Sampling uses the synchronized SCL rising edge, so a bit is sampled 2–3 clk cycles after the pad edge.
- Driving: ACK or data bit on SDA is updated 1 clk cycle after the synchronized SCL fall. It is held until the next synchronized SCL fall.
- SDA is released on the SCL fall that ends the ACK slot or the last data bit.
- busy rises on the cycle ACK_ADDR is entered. It falls on the cycle STOP is detected.
- Read byte is latched from the register file on entry to RDATA, so the value is stable for the whole byte.

## Configuration
- TOUCH_EMU_INT_EN defined: int_n goes low for exactly INT_PULSE_CYC cycles starting the cycle after a commit. A commit during an active pulse restarts the count.
- TOUCH_EMU_INT_EN undefined: int_n is tied 1, with no pulse counter, and the driver must poll 0x814E.

## Structure
- Shared package touch_emu_pkg: state enum, register addresses (REG_PID0, REG_STATUS, REG_PT1_XL…), STATUS_READY mask, product ID bytes.
- One sub-module, i2c_bus_sync: 2-FF synchronizers plus SCL rise/fall and START/STOP strobes.
- Register file, pending buffer and FSM live in the top.

## Test plan
- Idle probe: write addr 0x28 → ACK. Pointer 0x8140, repeated START, read 0x29 for 4 bytes, master NACK on the last → 0x39,0x31,0x34,0x37.
- inject (x=0x01E0, y=0x0110) while idle → status 0x81. Reading 0x814E then 0x8150–0x8153 → 0x81,(0x00),0xE0,0x01,0x10,0x01. int_n is low for 500 cycles (macro on).
- inject mid-read of 0x8150 → the current transfer returns the old X/Y. After STOP the new point is committed and status is 0x81.
- Write 0x00 to 0x814E → the next read of 0x814E returns 0x00.
- Address 0x2A (wrong) → no ACK, sda_oe=0 through the frame, busy=0.
- Pointer 0xFFFF, read 2 bytes → 0x00 then value at 0x0000 (0x00). Reset asserted mid-byte → sda_oe=0 in the same cycle and status cleared.
